// File: rtl/mem_stage_ctrl_pkg.sv
// Shared encodings for the memory stage: store size, load extension and FSM state codes.
package mem_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_DONE  = 2'b10,
    ST_DRAIN = 2'b11
  } state_t;

  localparam logic [1:0] SEL_WORD = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_BYTE = 2'b10;

  localparam logic [2:0] EXT_LW  = 3'b000;
  localparam logic [2:0] EXT_LBU = 3'b001;
  localparam logic [2:0] EXT_LB  = 3'b010;
  localparam logic [2:0] EXT_LHU = 3'b011;
  localparam logic [2:0] EXT_LH  = 3'b100;

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational store lane steering (strobes, replicated data) and load byte/half extraction.
module mem_lsu_align
  import mem_stage_ctrl_pkg::*;
(
  input  logic [1:0]  mem_in_sel,
  input  logic [2:0]  mem_out_sel,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    wstrb = 4'b1111;
    wdata = store_data;
    case (mem_in_sel)
      SEL_HALF: begin
        wstrb = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      SEL_BYTE: begin
        wstrb = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_byte = load_data[{off, 3'b000} +: 8];
    load_half = off[1] ? load_data[31:16] : load_data[15:0];
    case (mem_out_sel)
      EXT_LBU: rdata_ext = {24'h0, load_byte};
      EXT_LB:  rdata_ext = {{24{load_byte[7]}}, load_byte};
      EXT_LHU: rdata_ext = {16'h0, load_half};
      EXT_LH:  rdata_ext = {{16{load_half[15]}}, load_half};
      default: rdata_ext = load_data;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: E->M consumer handshake, single-outstanding data-bus transaction,
// post-flush draining of an accepted access, and optional registering of the extended load result.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int EXT_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              respon,
  input  logic              M_valid,
  input  logic              MemWriteM,
  input  logic              MemOrALUM,
  input  logic [1:0]        MemInSelM,
  input  logic [2:0]        MemOutSelM,
  input  logic              EXLM,
  input  logic [31:0]       ALUoutM,
  input  logic [31:0]       rd2M,
  input  logic              W_allowin,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              M_allowin,
  output logic              M_to_W_valid,
  output logic              data_req,
  output logic              data_wr,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  output logic [31:0]       mem_rdata_ext
);

  state_t      state, state_next;
  logic        need_mem;
  logic        ready_go;
  logic        block_in;
  logic        latch_ext;
  logic [3:0]  strb_raw;
  logic [31:0] ext_comb;
  logic [31:0] ext_reg;

  mem_lsu_align u_align (
    .mem_in_sel  (MemInSelM),
    .mem_out_sel (MemOutSelM),
    .off         (ALUoutM[1:0]),
    .store_data  (rd2M),
    .load_data   (data_rdata),
    .wstrb       (strb_raw),
    .wdata       (data_wdata),
    .rdata_ext   (ext_comb)
  );

  assign need_mem   = M_valid & (MemWriteM | MemOrALUM) & ~EXLM & ~respon;
  assign data_wr    = MemWriteM;
  assign data_wstrb = MemWriteM ? strb_raw : 4'b0000;
  assign data_addr  = {ALUoutM[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      ext_reg <= 32'h0;
    end else begin
      state <= state_next;
      if (latch_ext) ext_reg <= ext_comb;
    end
  end

  always_comb begin
    state_next = state;
    data_req   = 1'b0;
    ready_go   = 1'b0;
    block_in   = 1'b0;
    latch_ext  = 1'b0;
    case (state)
      ST_IDLE: begin
        data_req = need_mem;
        ready_go = ~need_mem;
        if (need_mem && data_addr_ok) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        ready_go = data_data_ok;
        block_in = ~data_data_ok;
        if (data_data_ok) begin
          // Without the result register, W must accept on the data_ok cycle.
          if (respon || W_allowin || EXT_REG == 0) begin
            state_next = ST_IDLE;
          end else begin
            latch_ext  = 1'b1;
            state_next = ST_DONE;
          end
        end else if (respon) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DONE: begin
        ready_go = 1'b1;
        if (W_allowin || respon) state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        block_in = 1'b1;
        if (data_data_ok) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign M_allowin     = ~block_in & (~M_valid | (ready_go & W_allowin));
  assign M_to_W_valid  = M_valid & ready_go & ~respon & (state != ST_DRAIN);
  assign mem_rdata_ext = (state == ST_DONE) ? ext_reg : ext_comb;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: handshake timing, strobes/wdata, load extension, stall, drain.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        respon;
  logic        M_valid;
  logic        MemWriteM;
  logic        MemOrALUM;
  logic [1:0]  MemInSelM;
  logic [2:0]  MemOutSelM;
  logic        EXLM;
  logic [31:0] ALUoutM;
  logic [31:0] rd2M;
  logic        W_allowin;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        M_allowin;
  logic        M_to_W_valid;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] mem_rdata_ext;

  int checks = 0;
  int errors = 0;

  mem_stage_ctrl #(.ADDR_W(32), .EXT_REG(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .respon        (respon),
    .M_valid       (M_valid),
    .MemWriteM     (MemWriteM),
    .MemOrALUM     (MemOrALUM),
    .MemInSelM     (MemInSelM),
    .MemOutSelM    (MemOutSelM),
    .EXLM          (EXLM),
    .ALUoutM       (ALUoutM),
    .rd2M          (rd2M),
    .W_allowin     (W_allowin),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata),
    .M_allowin     (M_allowin),
    .M_to_W_valid  (M_to_W_valid),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_wstrb    (data_wstrb),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .mem_rdata_ext (mem_rdata_ext)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    respon = 0; M_valid = 0; MemWriteM = 0; MemOrALUM = 0; MemInSelM = SEL_WORD;
    MemOutSelM = EXT_LW; EXLM = 0; ALUoutM = 32'h0; rd2M = 32'h0; W_allowin = 1;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    #2;
    checks++;
    if ({data_req, M_to_W_valid, M_allowin} !== 3'b001) begin
      errors++;
      $display("FAIL reset_ctl: req/mtw/allow got %b exp 001", {data_req, M_to_W_valid, M_allowin});
    end
    checks++;
    if (mem_rdata_ext !== 32'h0) begin
      errors++;
      $display("FAIL reset_ext: got %h exp 00000000", mem_rdata_ext);
    end
    tick();
  endtask

  // addr_ok in c0, data_ok in c1 with W ready
  task automatic test_load(input string name, input logic [31:0] addr, input logic [2:0] sel,
                           input logic [31:0] exp_addr, input logic [31:0] rdata,
                           input logic [31:0] exp_ext);
    M_valid = 1; MemOrALUM = 1; MemOutSelM = sel; ALUoutM = addr; data_addr_ok = 1;
    #2;
    checks++;
    if ({data_req, data_wr, data_wstrb, M_allowin, M_to_W_valid} !== 8'b1_0_0000_0_0) begin
      errors++;
      $display("FAIL %s_c0: req/wr/strb/allow/mtw got %b exp 10000000", name,
               {data_req, data_wr, data_wstrb, M_allowin, M_to_W_valid});
    end
    checks++;
    if (data_addr !== exp_addr) begin
      errors++;
      $display("FAIL %s_addr: got %h exp %h", name, data_addr, exp_addr);
    end
    tick();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = rdata;
    #2;
    checks++;
    if ({data_req, M_to_W_valid, M_allowin} !== 3'b011 || mem_rdata_ext !== exp_ext) begin
      errors++;
      $display("FAIL %s_c1: req/mtw/allow %b exp 011, ext %h exp %h", name,
               {data_req, M_to_W_valid, M_allowin}, mem_rdata_ext, exp_ext);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_store(input string name, input logic [31:0] addr, input logic [1:0] sel,
                            input logic [31:0] rd2, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
    M_valid = 1; MemWriteM = 1; MemInSelM = sel; ALUoutM = addr; rd2M = rd2; data_addr_ok = 1;
    #2;
    checks++;
    if ({data_req, data_wr} !== 2'b11 || data_wstrb !== exp_strb || data_wdata !== exp_wdata) begin
      errors++;
      $display("FAIL %s: req/wr %b exp 11, strb %b exp %b, wdata %h exp %h", name,
               {data_req, data_wr}, data_wstrb, exp_strb, data_wdata, exp_wdata);
    end
    tick();
    data_addr_ok = 0; data_data_ok = 1;
    #2;
    checks++;
    if ({M_to_W_valid, M_allowin} !== 2'b11) begin
      errors++;
      $display("FAIL %s_ack: mtw/allow got %b exp 11", name, {M_to_W_valid, M_allowin});
    end
    tick();
    idle_inputs();
  endtask

  // data_ok at c3 while W is stalled until c5; result held in DONE
  task automatic test_stall();
    M_valid = 1; MemOrALUM = 1; MemOutSelM = EXT_LW; ALUoutM = 32'h200; data_addr_ok = 1;
    tick();
    data_addr_ok = 0; W_allowin = 0;
    for (int c = 1; c <= 2; c++) begin
      #2;
      checks++;
      if ({data_req, M_allowin, M_to_W_valid} !== 3'b000) begin
        errors++;
        $display("FAIL stall_wait_c%0d: req/allow/mtw got %b exp 000", c,
                 {data_req, M_allowin, M_to_W_valid});
      end
      tick();
    end
    data_data_ok = 1; data_rdata = 32'h1234_5678;
    #2;
    checks++;
    if ({M_to_W_valid, M_allowin} !== 2'b10 || mem_rdata_ext !== 32'h1234_5678) begin
      errors++;
      $display("FAIL stall_c3: mtw/allow %b exp 10, ext %h exp 12345678",
               {M_to_W_valid, M_allowin}, mem_rdata_ext);
    end
    tick();
    data_data_ok = 0; data_rdata = 32'hFFFF_0000;
    #2;
    checks++;
    if ({M_to_W_valid, M_allowin, data_req} !== 3'b100 || mem_rdata_ext !== 32'h1234_5678) begin
      errors++;
      $display("FAIL stall_c4: mtw/allow/req %b exp 100, ext %h exp 12345678",
               {M_to_W_valid, M_allowin, data_req}, mem_rdata_ext);
    end
    tick();
    W_allowin = 1;
    #2;
    checks++;
    if ({M_to_W_valid, M_allowin} !== 2'b11 || mem_rdata_ext !== 32'h1234_5678) begin
      errors++;
      $display("FAIL stall_c5: mtw/allow %b exp 11, ext %h exp 12345678",
               {M_to_W_valid, M_allowin}, mem_rdata_ext);
    end
    tick();
    idle_inputs();
  endtask

  // respon after address acceptance: the late data_ok must be swallowed
  task automatic test_drain();
    M_valid = 1; MemOrALUM = 1; ALUoutM = 32'h300; data_addr_ok = 1;
    tick();
    data_addr_ok = 0; respon = 1;
    #2;
    checks++;
    if ({M_allowin, M_to_W_valid, data_req} !== 3'b000) begin
      errors++;
      $display("FAIL drain_c1: allow/mtw/req got %b exp 000", {M_allowin, M_to_W_valid, data_req});
    end
    tick();
    respon = 0; M_valid = 0;
    for (int c = 2; c <= 4; c++) begin
      data_data_ok = (c == 4);
      #2;
      checks++;
      if ({M_allowin, M_to_W_valid, data_req} !== 3'b000) begin
        errors++;
        $display("FAIL drain_c%0d: allow/mtw/req got %b exp 000", c,
                 {M_allowin, M_to_W_valid, data_req});
      end
      tick();
    end
    data_data_ok = 0;
    #2;
    checks++;
    if (M_allowin !== 1'b1) begin
      errors++;
      $display("FAIL drain_c5: allow got %b exp 1", M_allowin);
    end
    M_valid = 1; MemOrALUM = 1;
    #2;
    checks++;
    if (data_req !== 1'b1) begin
      errors++;
      $display("FAIL drain_newreq: req got %b exp 1", data_req);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_exl_and_addr_wait();
    M_valid = 1; MemOrALUM = 1; EXLM = 1;
    #2;
    checks++;
    if ({data_req, M_to_W_valid, M_allowin} !== 3'b011) begin
      errors++;
      $display("FAIL exl: req/mtw/allow got %b exp 011", {data_req, M_to_W_valid, M_allowin});
    end
    tick();
    EXLM = 0;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if ({data_req, M_to_W_valid, M_allowin} !== 3'b100) begin
        errors++;
        $display("FAIL addr_hold_c%0d: req/mtw/allow got %b exp 100", c,
                 {data_req, M_to_W_valid, M_allowin});
      end
      tick();
    end
    respon = 1;
    #2;
    checks++;
    if ({data_req, M_to_W_valid} !== 2'b00) begin
      errors++;
      $display("FAIL respon_idle: req/mtw got %b exp 00", {data_req, M_to_W_valid});
    end
    tick();
    idle_inputs();
    M_valid = 1; MemOrALUM = 1;
    #2;
    checks++;
    if (data_req !== 1'b1) begin
      errors++;
      $display("FAIL respon_idle_nodrain: req got %b exp 1", data_req);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    M_valid = 1; MemOrALUM = 1; data_addr_ok = 1;
    tick();
    data_addr_ok = 0; reset = 1; M_valid = 0;
    tick();
    reset = 0; data_data_ok = 1; data_rdata = 32'hAAAA_5555;
    #2;
    checks++;
    if ({M_allowin, M_to_W_valid, data_req} !== 3'b100) begin
      errors++;
      $display("FAIL rst_wait_stale: allow/mtw/req got %b exp 100", {M_allowin, M_to_W_valid, data_req});
    end
    tick();
    data_data_ok = 0; M_valid = 1; MemOrALUM = 1;
    #2;
    checks++;
    if ({data_req, M_to_W_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rst_wait_newreq: req/mtw got %b exp 10", {data_req, M_to_W_valid});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    M_valid = 1; MemOrALUM = 1; ALUoutM = 32'h400; data_addr_ok = 1;
    tick();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0000_0011;
    #2;
    checks++;
    if ({M_to_W_valid, M_allowin} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_first: mtw/allow got %b exp 11", {M_to_W_valid, M_allowin});
    end
    tick();
    data_data_ok = 0; ALUoutM = 32'h408; MemOrALUM = 0; MemWriteM = 1; MemInSelM = SEL_WORD;
    rd2M = 32'h0BAD_F00D;
    #2;
    checks++;
    if ({data_req, data_wr, data_wstrb} !== 6'b11_1111 || data_addr !== 32'h408) begin
      errors++;
      $display("FAIL b2b_second: req/wr/strb %b exp 111111, addr %h exp 00000408",
               {data_req, data_wr, data_wstrb}, data_addr);
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load("lw",  32'h104, EXT_LW,  32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    test_load("lb",  32'h103, EXT_LB,  32'h100, 32'h8012_3456, 32'hFFFF_FF80);
    test_load("lbu", 32'h103, EXT_LBU, 32'h100, 32'h8012_3456, 32'h0000_0080);
    test_load("lhu", 32'h102, EXT_LHU, 32'h100, 32'h8012_3456, 32'h0000_8012);
    test_load("lh0", 32'h100, EXT_LH,  32'h100, 32'h8012_F456, 32'hFFFF_F456);
    test_load("lb1", 32'h101, EXT_LB,  32'h100, 32'h8012_3456, 32'h0000_0034);
    test_store("sh",  32'h102, SEL_HALF, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
    test_store("sh0", 32'h100, SEL_HALF, 32'h0000_ABCD, 4'b0011, 32'hABCD_ABCD);
    test_store("sb",  32'h101, SEL_BYTE, 32'h0000_ABCD, 4'b0010, 32'hCDCD_CDCD);
    test_store("sb3", 32'h103, SEL_BYTE, 32'h0000_0077, 4'b1000, 32'h7777_7777);
    test_store("sw",  32'h108, SEL_WORD, 32'h1357_9BDF, 4'b1111, 32'h1357_9BDF);
    test_stall();
    test_drain();
    test_exl_and_addr_wait();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
